// File: rtl/ov7670_cfg_pkg.sv
// Shared constants for the OV7670 configuration sequencer: FSM states, table markers, sensor registers.
package ov7670_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_DONE,
    S_DELAY,
    S_NEXT,
    S_FINISH
  } cfg_state_t;

  localparam logic [7:0]  ADDR_END   = 8'hFF;
  localparam logic [7:0]  ADDR_DELAY = 8'hF0;
  localparam logic [15:0] ENTRY_END  = {ADDR_END, 8'hFF};

  localparam logic [7:0] REG_CLKRC = 8'h11;
  localparam logic [7:0] REG_COM7  = 8'h12;
  localparam logic [7:0] REG_COM3  = 8'h0C;
  localparam logic [7:0] REG_COM10 = 8'h15;
  localparam logic [7:0] REG_TSLB  = 8'h3A;
  localparam logic [7:0] REG_COM15 = 8'h40;

  function automatic logic [15:0] ent(input logic [7:0] a, input logic [7:0] v);
    return {a, v};
  endfunction

endpackage

// File: rtl/ov7670_cfg_rom.sv
// Sensor bring-up table: index -> {reg addr, value}; unlisted indices read as the end marker.
module ov7670_cfg_rom
  import ov7670_cfg_pkg::*;
#(
  parameter int unsigned IW = 6
) (
  input  logic [IW-1:0] idx_i,
  output logic [15:0]   entry_o
);

  always_comb begin
    case (32'(idx_i))
      0:       entry_o = ent(REG_COM7, 8'h80);   // soft reset
      1:       entry_o = ent(ADDR_DELAY, 8'h03); // let the sensor come out of reset
      2:       entry_o = ent(REG_CLKRC, 8'h01);
      3:       entry_o = ent(REG_COM15, 8'hD0);
      4:       entry_o = ent(REG_COM7, 8'h04);
      5:       entry_o = ent(REG_COM3, 8'h00);
      6:       entry_o = ent(REG_TSLB, 8'h04);
      7:       entry_o = ent(ADDR_DELAY, 8'h00);
      8:       entry_o = ent(REG_COM10, 8'h00);
      default: entry_o = ENTRY_END;
    endcase
  end

endmodule

// File: rtl/ov7670_cfg_seq.sv
// Walks the OV7670 bring-up table and issues one SCCB write per entry via newd/busy/done.
// Optional OV7670_CFG_TIMEOUT_EN bounds the waits on the SCCB master and raises a sticky cfg_err_o.
module ov7670_cfg_seq
  import ov7670_cfg_pkg::*;
#(
  parameter int unsigned ROM_DEPTH         = 64,
  parameter int unsigned DELAY_UNIT_CYCLES = 24000,
  parameter int unsigned TIMEOUT_CYCLES    = 16384
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       sccb_busy_i,
  input  logic       sccb_done_i,
  output logic       sccb_newd_o,
  output logic [7:0] sccb_reg_addr_o,
  output logic [7:0] sccb_data_o,
  output logic       cfg_busy_o,
  output logic       cfg_done_o,
  output logic       cfg_err_o
);

  localparam int unsigned IW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(ROM_DEPTH - 1);

  cfg_state_t    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    addr_q, addr_d, data_q, data_d;
  logic          newd_q, newd_d, busy_q, busy_d, done_q, done_d;
  logic [31:0]   dly_q, dly_d;
  logic [15:0]   rom_entry;

`ifdef OV7670_CFG_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
  logic        err_q, err_d;
`else
  localparam int unsigned tmo_unused = TIMEOUT_CYCLES;
`endif

  ov7670_cfg_rom #(.IW(IW)) u_rom (
    .idx_i   (idx_q),
    .entry_o (rom_entry)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    newd_d  = newd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dly_d   = dly_q;
`ifdef OV7670_CFG_TIMEOUT_EN
    tmo_d   = tmo_q + 32'd1;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: if (start_i) begin
        busy_d  = 1'b1;
        idx_d   = '0;
        state_d = S_FETCH;
`ifdef OV7670_CFG_TIMEOUT_EN
        err_d   = 1'b0;
`endif
      end
      S_FETCH: begin
        if (rom_entry == ENTRY_END) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_FINISH;
        end else if (rom_entry[15:8] == ADDR_DELAY) begin
          dly_d   = 32'(rom_entry[7:0]) * DELAY_UNIT_CYCLES;
          state_d = S_DELAY;
        end else begin
          addr_d  = rom_entry[15:8];
          data_d  = rom_entry[7:0];
          newd_d  = 1'b1;
          state_d = S_ISSUE;
`ifdef OV7670_CFG_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      // done before busy belongs to someone else's transaction; only busy moves us on
      S_ISSUE: begin
        if (sccb_busy_i) begin
          newd_d  = 1'b0;
          state_d = S_WAIT_DONE;
`ifdef OV7670_CFG_TIMEOUT_EN
          tmo_d   = '0;
        end else if (tmo_q >= TIMEOUT_CYCLES - 1) begin
          newd_d  = 1'b0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_FINISH;
`endif
        end
      end
      S_WAIT_DONE: begin
        if (sccb_done_i) begin
          state_d = S_NEXT;
`ifdef OV7670_CFG_TIMEOUT_EN
        end else if (tmo_q >= TIMEOUT_CYCLES - 1) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_FINISH;
`endif
        end
      end
      // a load of N spends exactly N cycles here (a zero load still takes one)
      S_DELAY: begin
        if (dly_q <= 32'd1) begin
          dly_d   = '0;
          state_d = S_NEXT;
        end else begin
          dly_d   = dly_q - 32'd1;
        end
      end
      S_NEXT: begin
        if (idx_q == LAST_IDX) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      newd_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dly_q   <= '0;
`ifdef OV7670_CFG_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      newd_q  <= newd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dly_q   <= dly_d;
`ifdef OV7670_CFG_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

  assign sccb_newd_o     = newd_q;
  assign sccb_reg_addr_o = addr_q;
  assign sccb_data_o     = data_q;
  assign cfg_busy_o      = busy_q;
  assign cfg_done_o      = done_q;
`ifdef OV7670_CFG_TIMEOUT_EN
  assign cfg_err_o       = err_q;
`else
  assign cfg_err_o       = 1'b0;
`endif

endmodule

// File: doc/ov7670_cfg_seq.md
Name: ov7670_cfg_seq

Overview:
Upstream stage of the SCCB master. It walks an internal table of {register address, value} pairs for the OV7670 and issues one SCCB write per entry over the master's newd/busy/done handshake. Reserved table entries insert millisecond delays (for example after the soft reset 0x12=0x80) or terminate the sequence. It runs in the same 24 MHz clock domain as the SCCB master's transaction logic and reports overall completion to the system.

Parameters:
ROM_DEPTH, 64, number of table entries; index width is clog2(ROM_DEPTH).
DELAY_UNIT_CYCLES, 24000, clk cycles per delay unit (1 ms at 24 MHz); testbenches override it to a small value.
TIMEOUT_CYCLES, 16384, maximum cycles to wait for sccb_done (only used with the optional feature).

Ports:
clk  in  1  24 MHz clock shared with the SCCB master.
rst  in  1  synchronous, active-low reset; one clock.
start  in  1  level/pulse; sampled only in IDLE to begin a sequence.
sccb_busy  in  1  from the master; high while a transaction is in progress.
sccb_done  in  1  from the master; 1-cycle pulse when a transaction ends.
sccb_newd  out  1  request to the master.
sccb_reg_addr  out  8  register address to the master.
sccb_data  out  8  register value to the master.
cfg_busy  out  1  high from start acceptance until the sequence ends.
cfg_done  out  1  1-cycle pulse when the end marker is reached or the table is exhausted.
cfg_err  out  1  sticky error flag (optional feature only; otherwise tied 0).

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, index=0, all outputs 0, delay and timeout counters 0. A reset mid-sequence drops sccb_newd on that edge and abandons the in-flight transaction.
- Table entry format: {addr[15:8], val[7:0]}.
  - addr=0xFF, val=0xFF: end marker.
  - addr=0xF0: delay of val*DELAY_UNIT_CYCLES cycles; val=0 means no delay.
  - Any other value: SCCB write.
- IDLE: when start=1, set cfg_busy=1, index=0, go to FETCH. start is ignored in all other states.
- FETCH: 1 cycle; register the table entry at index.
  - End marker -> FINISH.
  - Delay entry -> DELAY with counter loaded to val*DELAY_UNIT_CYCLES (32-bit product).
  - Otherwise -> ISSUE.
- ISSUE: drive sccb_reg_addr/sccb_data and set sccb_newd=1. Hold newd, addr and data stable until sccb_busy=1 is sampled, then clear newd on the next edge and go to WAIT_DONE. Addr/data remain stable through WAIT_DONE.
- WAIT_DONE: when sccb_done=1, go to NEXT.
- DELAY: decrement the counter each cycle; at 0, go to NEXT.
- NEXT: if index==ROM_DEPTH-1 -> FINISH (no wrap); otherwise index+1 -> FETCH.
- FINISH: cfg_done=1 for exactly one cycle, cfg_busy=0, then IDLE. A new start is accepted the cycle after FINISH.
- Minimum gap between consecutive writes: 3 cycles after sccb_done (NEXT, FETCH, ISSUE). This is safe because the master returns to idle on the same edge it pulses done.
- If sccb_done arrives in ISSUE before busy is seen, it is ignored.

Optional Feature:
OV7670_CFG_TIMEOUT_EN
- Defined:
  - WAIT_DONE and the busy-wait in ISSUE each count cycles. At TIMEOUT_CYCLES the block sets cfg_err=1 (sticky until reset or the next accepted start), drops newd, and goes to FINISH (cfg_done still pulses).
  - The counter restarts on each state entry.
- Undefined: no counter; cfg_err is tied to 0 and waits are unbounded.

Decomposition:
- Package ov7670_cfg_pkg holds:
  - state encoding constants;
  - marker constants ADDR_END=0xFF, ADDR_DELAY=0xF0;
  - OV7670 register address constants (COM7=0x12, CLKRC=0x11, COM15=0x40, ...).
- One sub-module, ov7670_cfg_rom: a combinational/case ROM mapping index to a 16-bit entry, holding the sensor bring-up table.

Test Plan:
- Table {0x12,0x80},{0x11,0x01},{0xFF,0xFF}; pulse start, with a behavioural master model (busy 1 cycle after newd, done after 100 cycles) -> exactly 2 writes, addr/data 0x12/0x80 then 0x11/0x01, newd dropped within 1 cycle of busy, one cfg_done pulse, cfg_busy then 0.
- Table {0x12,0x80},{0xF0,0x03},{0x40,0xD0},{0xFF,0xFF}, DELAY_UNIT_CYCLES=10 -> the second newd rises 30 cycles after leaving NEXT for DELAY (±3 cycles of control overhead).
- Table with no end marker, ROM_DEPTH=4, four writes -> 4 transactions, then cfg_done; index does not wrap.
- Assert rst=0 during WAIT_DONE of the 2nd write -> next edge: newd=0, cfg_busy=0, cfg_done=0; a following start restarts at entry 0.
- Assert start while cfg_busy=1 -> ignored; transaction count unchanged.
- With OV7670_CFG_TIMEOUT_EN and TIMEOUT_CYCLES=50, master never asserts done -> cfg_err=1 after 50 cycles in WAIT_DONE, cfg_done pulses once, newd=0.
